reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 5, address width; depth SHALL be 2^AW entries.
REQ-003 Parameter ZERO_REG, default 1, when 1 entry 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to read ports.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 read_addr1  input  AW  read port 1 address.
REQ-008 read_addr2  input  AW  read port 2 address.
REQ-009 RD1  output  DW  read port 1 data, combinational.
REQ-010 RD2  output  DW  read port 2 data, combinational.
REQ-011 write_addr  input  AW  write address.
REQ-012 WD  input  DW  write data.
REQ-013 wEna  input  1  write enable.
REQ-014 wBE  input  DW/8  byte enables; bit k qualifies WD[8k+7:8k].
REQ-015 clr_req  input  1  single-cycle pulse requesting a full-array clear.
REQ-016 clr_busy  output  1  high while the clear sequence runs.
REQ-017 clr_done  output  1  one-cycle pulse when the clear sequence completes.

Function
REQ-018 On a rising clk edge with wEna=1 and clr_busy=0, each byte k of entry write_addr with wBE[k]=1 SHALL take WD byte k; bytes with wBE[k]=0 SHALL hold.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0, bypass included.
REQ-020 RDn SHALL equal the stored entry at read_addrn in the same cycle (zero latency).
REQ-021 With BYPASS=1, wEna=1, clr_busy=0 and write_addr==read_addrn, RDn SHALL return the stored entry with enabled bytes replaced by WD bytes; with BYPASS=0, RDn SHALL return the pre-write value.
REQ-022 Both read ports SHALL operate independently, including identical addresses.
REQ-023 Clear FSM states: IDLE, CLEAR, DONE.
REQ-024 IDLE -> CLEAR on clr_req=1; clear pointer loads 0.
REQ-025 In CLEAR, one entry per cycle SHALL be written to 0 at the pointer, pointer increments; entry 2^AW-1 cleared -> DONE (clear takes exactly 2^AW cycles).
REQ-026 DONE SHALL last one cycle, assert clr_done, then return to IDLE.
REQ-027 clr_busy SHALL be 1 in CLEAR and DONE, 0 in IDLE.
REQ-028 While clr_busy=1, wEna writes SHALL be dropped, clr_req ignored, bypass disabled; reads return current array contents (cleared entries read 0).
REQ-029 clr_req and wEna asserted in the same IDLE cycle: write SHALL be performed, then clear starts next cycle and erases it.
REQ-030 Pointer SHALL not wrap; no entry cleared twice per sequence.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, set all entries to 0, FSM to IDLE, pointer to 0, clr_busy=0, clr_done=0.
REQ-032 Reset asserted mid-clear SHALL abort the sequence; no clr_done pulse.
REQ-033 First write after rst_n deasserts SHALL take effect on the first rising edge with wEna=1.

Verification
REQ-034 Reset, write 0xDEADBEEF to addr 5, wBE=4'hF -> next cycle RD1 with read_addr1=5 reads 0xDEADBEEF.
REQ-035 Entry 7 = 0x11223344, write WD=0xAABBCCDD wBE=4'b0101 -> entry 7 reads 0x11BB33DD; same-cycle RD2 (read_addr2=7, BYPASS=1) reads 0x11BB33DD, BYPASS=0 reads 0x11223344.
REQ-036 Write 0xFFFFFFFF to addr 0 (ZERO_REG=1) -> RD1/RD2 at addr 0 read 0, also in the write cycle.
REQ-037 Fill all 32 entries nonzero, pulse clr_req -> clr_busy high 33 cycles, clr_done high exactly in cycle 33 after clr_req, all entries 0 afterwards; wEna during busy leaves array 0.
REQ-038 Pulse clr_req, assert rst_n=0 at cycle 10 between clock edges -> outputs and entries 0 immediately, no clr_done, FSM IDLE.

Source files
------------

// File: rtl/reg_file_param_if.sv
// Register-file access bundle: two read ports, one byte-masked write port and
// the clear-sequence handshake.
//   master : drives addresses, write data/enables and clr_req; receives RD1/RD2,
//            clr_busy, clr_done
//   slave  : the register file side of the same signals
interface reg_file_param_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic [AW-1:0]   read_addr1;
    logic [AW-1:0]   read_addr2;
    logic [DW-1:0]   RD1;
    logic [DW-1:0]   RD2;
    logic [AW-1:0]   write_addr;
    logic [DW-1:0]   WD;
    logic            wEna;
    logic [DW/8-1:0] wBE;
    logic            clr_req;
    logic            clr_busy;
    logic            clr_done;

    modport master (
        output read_addr1, read_addr2, write_addr, WD, wEna, wBE, clr_req,
        input  RD1, RD2, clr_busy, clr_done
    );

    modport slave (
        input  read_addr1, read_addr2, write_addr, WD, wEna, wBE, clr_req,
        output RD1, RD2, clr_busy, clr_done
    );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised 2-read / 1-write register file with byte enables, optional
// hardwired-zero entry 0, optional write-to-read forwarding and a sequential
// full-array clear engine (one entry per cycle).
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset, clears array and clear engine
//   bus   : reg_file_param_if slave (read ports, write port, clear handshake)
module reg_file_param #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input logic              clk,
    input logic              rst_n,
    reg_file_param_if.slave  bus
);
    localparam int unsigned Depth = 1 << AW;
    localparam int unsigned NB    = DW / 8;

    typedef enum logic [1:0] {StIdle, StClear, StDone} clr_state_e;

    logic [DW-1:0] mem_q [Depth];
    clr_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy;
    logic          wr_en;
    logic          fwd_en;

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_val,
                                                 input logic [DW-1:0] new_val,
                                                 input logic [NB-1:0] be);
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign busy         = (state_q != StIdle);
    assign bus.clr_busy = busy;
    assign bus.clr_done = (state_q == StDone);

    // Writes to a hardwired-zero entry are dropped so the stored value stays 0.
    assign wr_en  = bus.wEna && !busy && !((ZERO_REG != 0) && (bus.write_addr == '0));
    assign fwd_en = (BYPASS != 0) && bus.wEna && !busy;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                // Pointer holds at the last entry instead of wrapping.
                if (ptr_q == {AW{1'b1}}) begin
                    state_d = StDone;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (state_q == StClear) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_en) begin
            mem_q[bus.write_addr] <= byte_merge(mem_q[bus.write_addr], bus.WD, bus.wBE);
        end
    end

    // Zero forcing is applied last so it also overrides forwarded data.
    always_comb begin
        bus.RD1 = mem_q[bus.read_addr1];
        if (fwd_en && (bus.write_addr == bus.read_addr1)) begin
            bus.RD1 = byte_merge(mem_q[bus.read_addr1], bus.WD, bus.wBE);
        end
        if ((ZERO_REG != 0) && (bus.read_addr1 == '0)) bus.RD1 = '0;
    end

    always_comb begin
        bus.RD2 = mem_q[bus.read_addr2];
        if (fwd_en && (bus.write_addr == bus.read_addr2)) begin
            bus.RD2 = byte_merge(mem_q[bus.read_addr2], bus.WD, bus.wBE);
        end
        if ((ZERO_REG != 0) && (bus.read_addr2 == '0)) bus.RD2 = '0;
    end
endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;
    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] wd;
    logic        we;
    logic [3:0]  be;
    logic        creq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 0 = defaults (zero reg, bypass), 1 = neither.
    logic [31:0] mdl [2][32];
    bit          zr  [2] = '{1'b1, 1'b0};
    bit          byp [2] = '{1'b1, 1'b0};
    int          clr_cnt;  // 0 idle, 1..32 clearing entry clr_cnt-1, 33 done

    reg_file_param_if #(.DW(32), .AW(5)) bus_a ();
    reg_file_param_if #(.DW(32), .AW(5)) bus_b ();

    assign bus_a.read_addr1 = ra1;
    assign bus_a.read_addr2 = ra2;
    assign bus_a.write_addr = wa;
    assign bus_a.WD         = wd;
    assign bus_a.wEna       = we;
    assign bus_a.wBE        = be;
    assign bus_a.clr_req    = creq;
    assign bus_b.read_addr1 = ra1;
    assign bus_b.read_addr2 = ra2;
    assign bus_b.write_addr = wa;
    assign bus_b.WD         = wd;
    assign bus_b.wEna       = we;
    assign bus_b.wBE        = be;
    assign bus_b.clr_req    = creq;

    reg_file_param #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    reg_file_param #(.DW(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_val[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input logic [4:0] addr);
        logic [31:0] v;
        v = mdl[d][addr];
        if (byp[d] && we && clr_cnt == 0 && wa == addr) v = merge(v, wd, be);
        if (zr[d] && addr == 5'd0) v = 32'd0;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) for (int a = 0; a < 32; a++) mdl[d][a] = 32'd0;
        clr_cnt = 0;
    endtask

    task automatic check_outputs();
        check("a_rd1", bus_a.RD1, exp_rd(0, ra1));
        check("a_rd2", bus_a.RD2, exp_rd(0, ra2));
        check("b_rd1", bus_b.RD1, exp_rd(1, ra1));
        check("b_rd2", bus_b.RD2, exp_rd(1, ra2));
        check("a_busy", 32'(bus_a.clr_busy), 32'(clr_cnt != 0));
        check("a_done", 32'(bus_a.clr_done), 32'(clr_cnt == 33));
        check("b_busy", 32'(bus_b.clr_busy), 32'(clr_cnt != 0));
        check("b_done", 32'(bus_b.clr_done), 32'(clr_cnt == 33));
    endtask

    task automatic tick();
        @(posedge clk);
        if (clr_cnt == 0) begin
            for (int d = 0; d < 2; d++) begin
                if (we && !(zr[d] && wa == 5'd0)) mdl[d][wa] = merge(mdl[d][wa], wd, be);
            end
            if (creq) clr_cnt = 1;
        end else if (clr_cnt <= 32) begin
            for (int d = 0; d < 2; d++) mdl[d][clr_cnt-1] = 32'd0;
            clr_cnt++;
        end else begin
            clr_cnt = 0;
        end
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        tick();
    endtask

    task automatic rand_inputs(input bit allow_clr);
        wa  = 5'($urandom_range(31, 0));
        ra1 = ($urandom_range(2, 0) == 0) ? wa : 5'($urandom_range(31, 0));
        ra2 = ($urandom_range(2, 0) == 0) ? wa : 5'($urandom_range(31, 0));
        wd  = $urandom;
        be  = 4'($urandom_range(15, 0));
        we  = ($urandom_range(3, 0) != 0);
        creq = allow_clr && ($urandom_range(39, 0) == 0);
    endtask

    int busy_cnt;
    int done_at;
    int done_seen;

    initial begin
        rst_n = 1'b1;
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0; be = '0; creq = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", 32'(bus_a.clr_busy), 32'd0);
        check("rst_done", 32'(bus_a.clr_done), 32'd0);
        check("rst_rd1", bus_b.RD1, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Full-word write then read back.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; be = 4'hF;
        step();
        we = 1'b0; ra1 = 5'd5;
        @(negedge clk); check_outputs();
        check("deadbeef", bus_a.RD1, 32'hDEADBEEF);
        tick();

        // Byte-masked write with and without forwarding.
        we = 1'b1; wa = 5'd7; wd = 32'h11223344; be = 4'hF;
        step();
        wd = 32'hAABBCCDD; be = 4'b0101; ra2 = 5'd7;
        @(negedge clk); check_outputs();
        check("byp_on", bus_a.RD2, 32'h11BB33DD);
        check("byp_off", bus_b.RD2, 32'h11223344);
        tick();
        we = 1'b0; ra1 = 5'd7;
        @(negedge clk); check_outputs();
        check("merged_a", bus_a.RD1, 32'h11BB33DD);
        check("merged_b", bus_b.RD1, 32'h11BB33DD);
        tick();

        // Entry 0 hardwired to zero, including the write cycle.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; be = 4'hF; ra1 = 5'd0; ra2 = 5'd0;
        @(negedge clk); check_outputs();
        check("zero_wr_rd1", bus_a.RD1, 32'd0);
        check("zero_wr_rd2", bus_a.RD2, 32'd0);
        tick();
        we = 1'b0;
        @(negedge clk); check_outputs();
        check("zero_rd1", bus_a.RD1, 32'd0);
        check("nozero_rd1", bus_b.RD1, 32'hFFFFFFFF);
        tick();

        // Randomised traffic with occasional clears.
        repeat (400) begin
            rand_inputs(1'b1);
            step();
        end
        creq = 1'b0; we = 1'b0;
        for (int i = 0; i < 40 && clr_cnt != 0; i++) step();

        // Fill everything, then clear with writes attempted during busy.
        for (int a = 0; a < 32; a++) begin
            we = 1'b1; wa = 5'(a); wd = $urandom | 32'h1; be = 4'hF;
            step();
        end
        we = 1'b0; creq = 1'b1;
        step();
        creq = 1'b0;
        busy_cnt = 0; done_at = 0;
        for (int n = 1; n <= 40; n++) begin
            rand_inputs(1'b0);
            if (n > 33) we = 1'b0;
            @(negedge clk); check_outputs();
            if (bus_a.clr_busy) busy_cnt++;
            if (bus_a.clr_done && done_at == 0) done_at = n;
            tick();
        end
        check("busy_len", 32'(busy_cnt), 32'd33);
        check("done_cycle", 32'(done_at), 32'd33);
        we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(a);
            @(negedge clk);
            check("clr_a", bus_a.RD1, 32'd0);
            check("clr_b", bus_b.RD2, 32'd0);
            tick();
        end

        // Reset in the middle of a clear sequence.
        for (int a = 1; a < 32; a++) begin
            we = 1'b1; wa = 5'(a); wd = 32'h5A5A0000 | 32'(a); be = 4'hF;
            step();
        end
        we = 1'b0; creq = 1'b1;
        step();
        creq = 1'b0;
        repeat (9) step();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", 32'(bus_a.clr_busy), 32'd0);
        check("mid_rst_done", 32'(bus_a.clr_done), 32'd0);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #1;
            check("mid_rst_a", bus_a.RD1, 32'd0);
            check("mid_rst_b", bus_b.RD2, 32'd0);
        end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_a.clr_done || bus_a.clr_busy) done_seen++;
        end
        @(posedge clk);
        #2 rst_n = 1'b1;

        // First write after reset release lands on the first edge.
        we = 1'b1; wa = 5'd9; wd = 32'hCAFEF00D; be = 4'hF;
        step();
        we = 1'b0; ra1 = 5'd9;
        @(negedge clk); check_outputs();
        check("first_wr", bus_a.RD1, 32'hCAFEF00D);
        tick();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus_a.clr_done || bus_a.clr_busy) done_seen++;
            tick();
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
